// File: rtl/png_chunk_pack.sv
// PNG chunk serializer: emits length, type, data and CRC words, feeding type+data to an external crc32 engine.
// All stream and CRC-feed outputs are registered; the data path has no output backpressure.
module png_chunk_pack (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start_i,
   input  logic [30:0] len_i,
   input  logic [31:0] typ_i,
   output logic        rdy_o,
   input  logic        val_i,
   input  logic [31:0] dat_i,
   output logic        crc_start_o,
   output logic        crc_val_o,
   output logic [31:0] crc_dat_o,
   output logic        crc_lst_o,
   input  logic        crc_done_i,
   input  logic [31:0] crc_dat_i,
   output logic        val_o,
   output logic [31:0] dat_o,
   output logic        lst_o,
   output logic        busy_o
);

   localparam int DATA_WD = 32;
   localparam int LEN_WD  = 31;
   localparam int CNT_WD  = LEN_WD - 2;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_TYP, S_DAT, S_WCRC, S_CRC
   } state_t;

   state_t              state_q;
   logic [CNT_WD-1:0]   cnt_q;
   logic [DATA_WD-1:0]  typ_q;
   logic [DATA_WD-1:0]  dat_q;
   logic [DATA_WD-1:0]  crc_dat_q;
   logic                val_q, lst_q, rdy_q, busy_q;
   logic                crc_start_q, crc_val_q, crc_lst_q;

   // Each state names the word visible on the outputs while it is current,
   // so every transition also loads the registered outputs for the next state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         typ_q       <= '0;
         dat_q       <= '0;
         crc_dat_q   <= '0;
         val_q       <= 1'b0;
         lst_q       <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
         crc_start_q <= 1'b0;
         crc_val_q   <= 1'b0;
         crc_lst_q   <= 1'b0;
      end else begin
         val_q       <= 1'b0;
         lst_q       <= 1'b0;
         crc_start_q <= 1'b0;
         crc_val_q   <= 1'b0;
         crc_lst_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_LEN;
                  cnt_q   <= len_i[LEN_WD-1:2];
                  typ_q   <= typ_i;
                  val_q   <= 1'b1;
                  dat_q   <= {1'b0, len_i};
                  busy_q  <= 1'b1;
               end
            end
            S_LEN: begin
               state_q     <= S_TYP;
               val_q       <= 1'b1;
               dat_q       <= typ_q;
               crc_start_q <= 1'b1;
               crc_val_q   <= 1'b1;
               crc_dat_q   <= typ_q;
               crc_lst_q   <= (cnt_q == '0);
            end
            S_TYP: begin
               if (cnt_q == '0) begin
                  state_q <= S_WCRC;
               end else begin
                  state_q <= S_DAT;
                  rdy_q   <= 1'b1;
               end
            end
            S_DAT: begin
               if (val_i) begin
                  val_q     <= 1'b1;
                  dat_q     <= dat_i;
                  crc_val_q <= 1'b1;
                  crc_dat_q <= dat_i;
                  cnt_q     <= cnt_q - 1'b1;
                  if (cnt_q == CNT_WD'(1)) begin
                     crc_lst_q <= 1'b1;
                     rdy_q     <= 1'b0;
                     state_q   <= S_WCRC;
                  end
               end
            end
            S_WCRC: begin
               // dat_q doubles as the latched CRC for the final word
               if (crc_done_i) begin
                  state_q <= S_CRC;
                  val_q   <= 1'b1;
                  lst_q   <= 1'b1;
                  dat_q   <= crc_dat_i;
               end
            end
            S_CRC: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rdy_o       = rdy_q;
   assign val_o       = val_q;
   assign dat_o       = dat_q;
   assign lst_o       = lst_q;
   assign busy_o      = busy_q;
   assign crc_start_o = crc_start_q;
   assign crc_val_o   = crc_val_q;
   assign crc_dat_o   = crc_dat_q;
   assign crc_lst_o   = crc_lst_q;

endmodule

// File: tb/tb_png_chunk_pack.sv
// Scoreboard bench for png_chunk_pack: expected stream and CRC-feed words are queued at drive time.
module tb_png_chunk_pack;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i, val_i, crc_done_i;
   logic [30:0] len_i;
   logic [31:0] typ_i, dat_i, crc_dat_i;
   logic        rdy_o, crc_start_o, crc_val_o, crc_lst_o, val_o, lst_o, busy_o;
   logic [31:0] crc_dat_o, dat_o;

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];
   logic [33:0] crc_q[$];

   png_chunk_pack dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .typ_i(typ_i),
      .rdy_o(rdy_o), .val_i(val_i), .dat_i(dat_i),
      .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
      .crc_lst_o(crc_lst_o), .crc_done_i(crc_done_i), .crc_dat_i(crc_dat_i),
      .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (val_o) begin
            if (exp_q.size() == 0) chk("out_unexpected", 64'(exp_q.size()), 64'd1);
            else chk("out_word", {lst_o, dat_o}, exp_q.pop_front());
         end
         if (crc_val_o) begin
            if (crc_q.size() == 0) chk("crc_unexpected", 64'(crc_q.size()), 64'd1);
            else chk("crc_feed", {crc_start_o, crc_lst_o, crc_dat_o}, crc_q.pop_front());
         end
      end
   end

   task automatic start_chunk(input logic [30:0] len, input logic [31:0] typ);
      start_i = 1'b1;
      len_i   = len;
      typ_i   = typ;
      exp_q.push_back({1'b0, 1'b0, len});
      exp_q.push_back({1'b0, typ});
      crc_q.push_back({1'b1, (len[30:2] == 29'd0), typ});
      tick;
      start_i = 1'b0;
      len_i   = 31'h1234_5678;
      typ_i   = 32'hFFFF_FFFF;
   endtask

   task automatic wait_rdy;
      for (int i = 0; i < 20 && rdy_o !== 1'b1; i++) tick;
      if (rdy_o !== 1'b1) chk("rdy_timeout", 64'(rdy_o), 64'd1);
   endtask

   task automatic send_word(input logic [31:0] d, input bit last, input int gap);
      repeat (gap) tick;
      wait_rdy;
      val_i = 1'b1;
      dat_i = d;
      exp_q.push_back({1'b0, d});
      crc_q.push_back({1'b0, last, d});
      tick;
      val_i = 1'b0;
      dat_i = 32'h5A5A_5A5A;
   endtask

   task automatic finish_crc(input logic [31:0] crc, input int dly, input bit pulse_in_crc);
      repeat (dly) tick;
      crc_done_i = 1'b1;
      crc_dat_i  = crc;
      exp_q.push_back({1'b1, crc});
      tick;
      crc_done_i = 1'b0;
      crc_dat_i  = 32'h0BAD_F00D;
      chk("busy_in_crc", 64'(busy_o), 64'd1);
      start_i = pulse_in_crc;
      tick;
      start_i = 1'b0;
      chk("busy_end", 64'(busy_o), 64'd0);
   endtask

   task automatic reset_now(input string tag);
      #2 rstn = 1'b0;
      #1;
      chk({tag, "_dat"}, {dat_o, crc_dat_o}, 64'd0);
      chk({tag, "_flags"}, {57'd0, val_o, lst_o, rdy_o, busy_o, crc_start_o, crc_val_o, crc_lst_o}, 64'd0);
      chk({tag, "_queues"}, 64'(exp_q.size() + crc_q.size()), 64'd0);
      @(posedge clk);
      #3 rstn = 1'b1;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; start_i = 1'b0; val_i = 1'b0; crc_done_i = 1'b0;
      len_i = '0; typ_i = '0; dat_i = '0; crc_dat_i = '0;
      #12;
      chk("reset_dat", {dat_o, crc_dat_o}, 64'd0);
      chk("reset_flags", {57'd0, val_o, lst_o, rdy_o, busy_o, crc_start_o, crc_val_o, crc_lst_o}, 64'd0);
      #10 rstn = 1'b1;
      tick;

      // IEND: empty chunk, CRC engine answers a couple of cycles later
      start_chunk(31'd0, 32'h4945_4E44);
      chk("busy_start", 64'(busy_o), 64'd1);
      chk("rdy_empty", 64'(rdy_o), 64'd0);
      finish_crc(32'hAE42_6082, 2, 1'b0);

      // Three data words back-to-back
      start_chunk(31'd12, 32'h4944_4154);
      send_word(32'h1111_0001, 1'b0, 0);
      send_word(32'h1111_0002, 1'b0, 0);
      send_word(32'h1111_0003, 1'b1, 0);
      chk("rdy_drop", 64'(rdy_o), 64'd0);
      finish_crc(32'hC0DE_0012, 0, 1'b0);

      // Three-cycle val_i gap between two words
      start_chunk(31'd8, 32'h7445_5874);
      send_word(32'h2222_0001, 1'b0, 0);
      send_word(32'h2222_0002, 1'b1, 3);
      finish_crc(32'hC0DE_0008, 1, 1'b0);

      // start_i pulsed in DAT, WCRC and the CRC-word cycle
      start_chunk(31'd8, 32'h6348_524D);
      send_word(32'h3333_0001, 1'b0, 0);
      start_i = 1'b1; len_i = 31'd4; typ_i = 32'hDEAD_0001;
      tick;
      start_i = 1'b0;
      chk("busy_dat_start", 64'(busy_o), 64'd1);
      send_word(32'h3333_0002, 1'b1, 0);
      start_i = 1'b1; len_i = 31'd0; typ_i = 32'hDEAD_0002;
      tick;
      start_i = 1'b0;
      chk("busy_wcrc_start", 64'(busy_o), 64'd1);
      finish_crc(32'hC0DE_0040, 0, 1'b1);
      tick;
      chk("no_queued_start", 64'(busy_o), 64'd0);

      // Stray crc_done_i in DAT must not end the chunk
      start_chunk(31'd8, 32'h7A54_5874);
      send_word(32'h4444_0001, 1'b0, 0);
      crc_done_i = 1'b1; crc_dat_i = 32'hDEAD_BEEF;
      tick;
      crc_done_i = 1'b0;
      send_word(32'h4444_0002, 1'b1, 0);
      finish_crc(32'hC0DE_0042, 4, 1'b0);

      // Reset mid-chunk, then a clean empty chunk
      start_chunk(31'd16, 32'h4944_4154);
      send_word(32'h5555_0001, 1'b0, 0);
      send_word(32'h5555_0002, 1'b0, 0);
      tick;
      reset_now("rst_mid");
      repeat (3) tick;
      start_chunk(31'd0, 32'h4945_4E44);
      finish_crc(32'hAE42_6082, 2, 1'b0);

      // Maximum length: counter must not look like it is near the end
      start_chunk(31'h7FFF_FFFC, 32'h4944_4154);
      send_word(32'h6666_0001, 1'b0, 0);
      send_word(32'h6666_0002, 1'b0, 0);
      tick;
      chk("rdy_max_len", 64'(rdy_o), 64'd1);
      reset_now("rst_max");

      repeat (3) tick;
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      chk("crc_q_empty", 64'(crc_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/png_chunk_pack.md
PNG_CHUNK_PACK -- requirements
Module: png_chunk_pack

Interface
REQ-001 Parameter: DATA_WD, 32, stream and CRC word width; fixed, not overridable.
REQ-002 Parameter: LEN_WD, 31, chunk byte-length width (PNG maximum 2^31-1).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 start_i  in  1  one-cycle pulse; begins a chunk; sampled only in IDLE.
REQ-006 len_i  in  LEN_WD  chunk data length in bytes; sampled with start_i; len_i[1:0] is 0 by contract.
REQ-007 typ_i  in  32  chunk type code, e.g. 32'h49444154 for "IDAT"; sampled with start_i.
REQ-008 rdy_o  out  1  data request; high in DAT state only.
REQ-009 val_i  in  1  data word valid; honoured only while rdy_o=1.
REQ-010 dat_i  in  32  data word, big-endian byte order.
REQ-011 crc_start_o, crc_val_o, crc_dat_o[31:0], crc_lst_o  out  crc32 engine feed.
REQ-012 crc_done_i  in  1  engine completion pulse.
REQ-013 crc_dat_i  in  32  engine result, valid with crc_done_i.
REQ-014 val_o  out  1  output word valid; no backpressure.
REQ-015 dat_o  out  32  serialized chunk word.
REQ-016 lst_o  out  1  marks the CRC word, the final word of a chunk.
REQ-017 busy_o  out  1  high from the cycle after an accepted start_i until the cycle after the CRC word.

Function
REQ-018 FSM states: IDLE, LEN, TYP, DAT, WCRC, CRC.
REQ-019 IDLE: start_i=1 -> LEN; latch len_i>>2 into word counter cnt and latch typ_i.
REQ-020 LEN (1 cycle): val_o=1, dat_o={1'b0,len}; no CRC feed; -> TYP.
REQ-021 TYP (1 cycle): val_o=1, dat_o=typ; crc_start_o=1, crc_val_o=1, crc_dat_o=typ; crc_lst_o=1 when cnt=0; -> WCRC if cnt=0, else DAT.
REQ-022 DAT: rdy_o=1; each val_i=1 -> val_o=1, dat_o=dat_i, crc_val_o=1, crc_dat_o=dat_i, cnt decrements; crc_lst_o=1 on the word where cnt=1, then -> WCRC.
REQ-023 DAT with val_i=0: no output, no CRC feed, cnt holds; no timeout.
REQ-024 WCRC: outputs idle; crc_done_i=1 -> latch crc_dat_i, -> CRC.
REQ-025 CRC (1 cycle): val_o=1, lst_o=1, dat_o=latched CRC; -> IDLE.
REQ-026 crc_done_i outside WCRC is ignored.
REQ-027 All stream and CRC-feed outputs are registered. Latency: start_i at cycle T gives the length word at T+1, the type word at T+2, and data from T+3 when val_i permits.
REQ-028 CRC covers type and data only, never the length word.
REQ-029 start_i outside IDLE is ignored; no queuing. start_i in the CRC-state cycle is also ignored.
REQ-030 val_i while rdy_o=0 is ignored; no dat_i capture.
REQ-031 The output stream carries exactly cnt+3 words per chunk.
REQ-032 Counter width is LEN_WD-2 bits; len_i=2^31-4 counts correctly with no wrap.

Reset
REQ-033 rstn=0 (asynchronous): state=IDLE; cnt, latched length, type and CRC = 0.
REQ-034 Outputs forced to 0 during reset: val_o, dat_o, lst_o, rdy_o, busy_o, crc_start_o, crc_val_o, crc_dat_o, crc_lst_o.
REQ-035 Reset mid-chunk abandons the chunk; no CRC word is emitted after release.
REQ-036 The first start_i after reset release is accepted normally.

Verification
REQ-037 IEND: len_i=0, typ_i=32'h49454E44, crc_dat_i=32'hAE426082 -> dat_o sequence 0, 49454E44, AE426082; lst_o on the last word; crc_start_o, crc_val_o and crc_lst_o all high in the type cycle.
REQ-038 len_i=12, three words streamed back-to-back -> 6 output words; crc_lst_o on the 3rd data word; rdy_o drops after it.
REQ-039 len_i=8 with a 3-cycle val_i gap between words -> no output during the gap; cnt holds; 5 output words total.
REQ-040 start_i pulsed during DAT and during WCRC -> ignored; the current chunk completes unchanged; busy_o stays high.
REQ-041 rstn asserted during DAT of a len_i=16 chunk -> all outputs 0 immediately; the next len_i=0 chunk is correct.
REQ-042 crc_done_i pulsed in DAT, then 5 cycles later in WCRC -> only the WCRC value appears on dat_o with lst_o=1.
